if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register, successor to the plain IF/ID latch.
- Adds valid/ready handshake, hazard stall via out_ready, branch flush with NOP bubble insertion, and a 2-entry skid buffer so stalls never drop a fetched instruction.
- Sits between the fetch unit/instruction memory and the decode stage.
- 1-cycle latency; full throughput while decode is ready.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 64, program-counter width in bits.
- NOP_INSTR, 32'h00000013, encoding driven on out_instr whenever out_valid=0 (width INSTR_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready.
- in_instr  input  INSTR_W  fetched instruction.
- in_pc  input  PC_W  PC of fetched instruction.
- flush  input  1  discard all held and incoming entries (taken branch/jump).
- out_valid  output  1  out_instr/out_pc hold a live instruction.
- out_ready  input  1  decode accepts; 0 = hazard stall.
- out_instr  output  INSTR_W  instruction to decode.
- out_pc  output  PC_W  PC to decode.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each has its own valid bit. All outputs are registered.
- in_ready = ~skid_valid. It is registered, with no combinational path from out_ready.
- acc = in_valid & in_ready & ~flush.
- drn = out_valid & out_ready.
- Reset (reset=0, async):
  - main_valid=0, skid_valid=0.
  - out_instr=NOP_INSTR, out_pc=0, occupancy=0, in_ready=1.
  - Reset takes effect mid-transfer; in-flight entries are lost.
- Flush (highest priority on the clock edge):
  - both valid bits cleared; out_instr=NOP_INSTR, out_pc=0.
  - An input presented in the same cycle is dropped.
  - A concurrent drn still counts as consumed by decode.
  - Next cycle: in_ready=1, occupancy=0.
- Normal update, by (main_valid, skid_valid):
  - (0,0): acc loads main. Otherwise no change.
  - (1,0), drn & acc: main <= input.
  - (1,0), drn & ~acc: main_valid <= 0; outputs return to NOP_INSTR/0.
  - (1,0), ~drn & acc: skid <= input, so in_ready=0 next cycle.
  - (1,0), ~drn & ~acc: hold.
  - (1,1), drn: main <= skid, skid_valid <= 0. acc is impossible because in_ready=0.
  - (1,1), ~drn: hold.
  - (0,1): unreachable; verification asserts it never occurs.
- Ordering: strict FIFO; skid data always precedes newer input.
- While out_valid=0, out_instr=NOP_INSTR and out_pc=0.
- occupancy = main_valid + skid_valid.
- Sustained out_ready=1 gives one instruction per cycle with occupancy ≤1.

Decomposition:
- Shared pipeline package holds:
  - INSTR_W/PC_W defaults and the NOP_INSTR constant;
  - a packed if_id_entry type {instr, pc}, reused by later stage registers (id_ex, ex_mem).
- Sub-module pipe_entry_reg: one entry plus valid bit, with load/clear controls.
- Instantiated twice (main, skid); the top holds only the control logic above.

Test Plan:
- Reset release, then in_valid=1 with instr 0x00A00093, pc 0x0; out_ready=1 throughout.
  - Next cycle: out_valid=1, out_instr=0x00A00093, out_pc=0x0, occupancy=1.
- Stream pc 0x0,0x4,0x8,0xC with out_ready=1.
  - Outputs appear one cycle later, back-to-back.
  - in_ready stays 1; occupancy never exceeds 1.
- Stall: out_ready=0 while pc 0x4 is held and pc 0x8 is presented.
  - 0x8 goes to skid; next cycle in_ready=0, occupancy=2.
  - Raise out_ready: 0x4 then 0x8 emitted in order; in_ready=1 one cycle after 0x4 drains.
- Flush with occupancy=2 and in_valid=1 (pc 0x10).
  - Next cycle: out_valid=0, out_instr=0x00000013, out_pc=0, occupancy=0, in_ready=1.
  - pc 0x10 never appears on the output.
- Assert reset=0 asynchronously mid-cycle while occupancy=1.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first accepted instruction appears with 1-cycle latency.
- Random in_valid/out_ready/flush (10k cycles) against a FIFO scoreboard.
  - No loss, duplication or reordering except for entries discarded by flush.
  - (main_valid=0, skid_valid=1) never occurs.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline definitions: default datapath widths, the NOP bubble encoding
// and the entry layout reused by every stage register.
package if_id_skid_reg_pkg;

  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_PC_W    = 64;
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc;
  } if_id_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_SKID  = 2'b01,  // skid without main: never reachable
    ST_MAIN  = 2'b10,
    ST_FULL  = 2'b11
  } fill_state_e;

endpackage

// File: rtl/if_id_skid_reg_entry.sv
// One pipeline entry plus its valid bit. Clear wins over load and parks the
// data at CLR_VAL so an empty entry always presents the bubble encoding.
module pipe_entry_reg #(
  parameter int unsigned    W       = 96,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VAL;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VAL;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush-to-bubble and a
// two-entry skid so a decode stall never loses a fetched instruction.
module if_id_skid_reg
  import if_id_skid_reg_pkg::*;
#(
  parameter int unsigned          INSTR_W   = DEF_INSTR_W,
  parameter int unsigned          PC_W      = DEF_PC_W,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [1:0]         occupancy
);

  localparam int unsigned         ENTRY_W = INSTR_W + PC_W;
  localparam logic [ENTRY_W-1:0]  CLR_VAL = {NOP_INSTR, {PC_W{1'b0}}};

  logic               main_valid, skid_valid;
  logic [ENTRY_W-1:0] main_data,  skid_data;
  logic               main_load,  main_clr, skid_load, skid_clr;
  logic [ENTRY_W-1:0] main_d;
  logic               main_valid_d, skid_valid_d;
  logic [1:0]         occupancy_d, occupancy_q;
  logic               acc, drn;
  fill_state_e        fill;

  assign fill = fill_state_e'({main_valid, skid_valid});
  // skid_valid is a flop, so in_ready never depends combinationally on out_ready
  assign acc  = in_valid & ~skid_valid & ~flush;
  assign drn  = main_valid & out_ready;

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = {in_instr, in_pc};
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (fill)
        ST_EMPTY: main_load = acc;
        ST_MAIN: begin
          if (drn && acc)       main_load = 1'b1;
          else if (drn)         main_clr  = 1'b1;
          else if (acc)         skid_load = 1'b1;
        end
        ST_FULL: begin
          if (drn) begin
            main_load = 1'b1;
            main_d    = skid_data;
            skid_clr  = 1'b1;
          end
        end
        ST_SKID: skid_clr = 1'b1;  // recover to empty rather than strand data
        default: ;
      endcase
    end

    main_valid_d = main_clr ? 1'b0 : (main_load ? 1'b1 : main_valid);
    skid_valid_d = skid_clr ? 1'b0 : (skid_load ? 1'b1 : skid_valid);
    occupancy_d  = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
  end

  pipe_entry_reg #(.W(ENTRY_W), .CLR_VAL(CLR_VAL)) u_main (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (main_load),
    .clear_i (main_clr),
    .d_i     (main_d),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_entry_reg #(.W(ENTRY_W), .CLR_VAL(CLR_VAL)) u_skid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .d_i     ({in_instr, in_pc}),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occupancy_q <= 2'd0;
    else        occupancy_q <= occupancy_d;
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_instr = main_data[ENTRY_W-1:PC_W];
  assign out_pc    = main_data[PC_W-1:0];
  assign occupancy = occupancy_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and randomised checks of if_id_skid_reg against hand-computed
// values and a FIFO scoreboard.
module tb_if_id_skid_reg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 64;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_ready, flush, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [1:0]         occupancy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .occupancy (occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_instr !== NOP) begin n_err++; $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); end
    n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first();
    in_valid = 1'b1; in_instr = 32'h00A0_0093; in_pc = 64'h0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL first_out_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_instr !== 32'h00A0_0093) begin n_err++; $display("FAIL first_out_instr got %h want 00a00093", out_instr); end
    n_cmp++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL first_out_pc got %h want 0", out_pc); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL first_occupancy got %0d want 1", occupancy); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== NOP) begin n_err++; $display("FAIL first_drain got v=%0b i=%h want v=0 i=%h", out_valid, out_instr, NOP); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h0010_0113 + 32'(i); in_pc = 64'(4 * i);
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'(4 * i) || out_instr !== 32'h0010_0113 + 32'(i)) begin
        n_err++; $display("FAIL stream_out[%0d] got v=%0b pc=%h i=%h want v=1 pc=%h", i, out_valid, out_pc, out_instr, 4 * i);
      end
      n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
        n_err++; $display("FAIL stream_flow[%0d] got rdy=%0b occ=%0d want rdy=1 occ=1", i, in_ready, occupancy);
      end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL stream_end got v=%0b occ=%0d want 0/0", out_valid, occupancy); end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_instr = 32'h0040_0213; in_pc = 64'h4;
    step();
    out_ready = 1'b0; in_instr = 32'h0080_0293; in_pc = 64'h8;
    step();
    n_cmp++; if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_pc !== 64'h4) begin
      n_err++; $display("FAIL stall_fill got rdy=%0b occ=%0d pc=%h want 0/2/4", in_ready, occupancy, out_pc);
    end
    in_instr = 32'h00C0_0313; in_pc = 64'hC;  // presented while full: must not be taken
    step();
    n_cmp++; if (occupancy !== 2'd2 || out_pc !== 64'h4 || out_instr !== 32'h0040_0213) begin
      n_err++; $display("FAIL stall_hold got occ=%0d pc=%h i=%h want 2/4/00400213", occupancy, out_pc, out_instr);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_pc !== 64'h8 || out_instr !== 32'h0080_0293 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL stall_drain1 got pc=%h i=%h rdy=%0b occ=%0d want 8/00800293/1/1", out_pc, out_instr, in_ready, occupancy);
    end
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL stall_drain2 got v=%0b pc=%h occ=%0d want 0/0/0", out_valid, out_pc, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0200_0013; in_pc = 64'h20;
    step();
    in_instr = 32'h0240_0013; in_pc = 64'h24;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_setup got occ=%0d want 2", occupancy); end
    in_valid = 1'b1; in_ready_flush: begin end
    in_instr = 32'h0100_0013; in_pc = 64'h10; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h0) begin
      n_err++; $display("FAIL flush_out got v=%0b i=%h pc=%h want 0/%h/0", out_valid, out_instr, out_pc, NOP);
    end
    n_cmp++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_flow got occ=%0d rdy=%0b want 0/1", occupancy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0 || out_pc === 64'h10) begin n_err++; $display("FAIL flush_ghost[%0d] got v=%0b pc=%h want v=0", i, out_valid, out_pc); end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_instr = 32'h0300_0013; in_pc = 64'h30;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL areset_setup got occ=%0d want 1", occupancy); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL areset_immediate got v=%0b i=%h pc=%h occ=%0d rdy=%0b want 0/%h/0/0/1", out_valid, out_instr, out_pc, occupancy, in_ready, NOP);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0400_0013; in_pc = 64'h40;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== 32'h0400_0013) begin
      n_err++; $display("FAIL areset_after got v=%0b pc=%h i=%h want 1/40/04000013", out_valid, out_pc, out_instr);
    end
    step();
  endtask

  task automatic test_random();
    logic [INSTR_W+PC_W-1:0] q[$];
    logic [INSTR_W+PC_W-1:0] head;
    logic [PC_W-1:0] next_pc = 64'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      n_cmp++; if (occupancy !== 2'(q.size()) || out_valid !== (q.size() != 0)) begin
        n_err++; $display("FAIL rand_occ[%0d] got occ=%0d v=%0b want occ=%0d", cyc, occupancy, out_valid, q.size());
      end
      if (!out_valid) begin
        n_cmp++; if (out_instr !== NOP || out_pc !== 64'h0) begin n_err++; $display("FAIL rand_bubble[%0d] got i=%h pc=%h", cyc, out_instr, out_pc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rand_illegal_state[%0d] skid without main", cyc); end
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(1) != 0);
      flush     = ($urandom_range(15) == 0);
      in_instr  = $urandom;
      in_pc     = next_pc;
      if (out_valid && out_ready) begin
        head = (q.size() != 0) ? q.pop_front() : '0;
        n_cmp++; if ({out_instr, out_pc} !== head) begin
          n_err++; $display("FAIL rand_order[%0d] got i=%h pc=%h want i=%h pc=%h", cyc, out_instr, out_pc, head[INSTR_W+PC_W-1:PC_W], head[PC_W-1:0]);
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back({in_instr, in_pc});
        next_pc = next_pc + 64'd4;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_first();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
